dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the single-cycle RV32I core: the slave end of the core's `dmem_addr` / `dmem_data` / `dmem_wen` interface. Holds a DEPTH-word register array and serves combinational loads and clocked stores. Zero-fills itself after reset and exposes a registered debug read port plus a store counter for the testbench and system monitor.

## Interface
Parameters:
- `XLEN`, 32, data word width.
- `DEPTH`, 32, number of words; power of two.
- `ADDR_BITS`, 5, `$clog2(DEPTH)`; index bits taken from `dmem_addr`.
- `CNT_W`, 16, width of the store counter.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in, 1: clock, rising edge.
- `reset` in, 1: asynchronous, active-low reset.
- `dmem_addr` in, XLEN: word index in bits `[ADDR_BITS-1:0]`; upper bits ignored.
- `dmem_wen` in, 1: core is storing this cycle.
- `dmem_data` inout, XLEN: core drives it when `dmem_wen=1`; this block drives it when `dmem_wen=0`.
- `mem_ready` out, 1: initialisation complete.
- `dbg_req_valid` in, 1: debug read request.
- `dbg_req_ready` out, 1: request accepted when both are high at the clock edge.
- `dbg_addr` in, ADDR_BITS: debug word index.
- `dbg_rsp_valid` out, 1: one-cycle pulse with the read data.
- `dbg_rsp_data` out, XLEN: debug read data; held until the next response.
- `wr_count` out, CNT_W: number of accepted core stores, saturating.

## Operation
- FSM states:
  - `CLEAR`: entered on reset. A clear index counts 0 to DEPTH-1, writing 0 to one word per cycle. After writing DEPTH-1, go to `RUN`.
  - `RUN`: terminal state until the next reset.
- Core read:
  - While `dmem_wen=0`, drive `dmem_data = mem[idx]`, combinationally, where `idx = dmem_addr[ADDR_BITS-1:0]`.
  - In `CLEAR`, drive 0 instead.
  - While `dmem_wen=1`, `dmem_data` is high-Z from this block.
- Core store:
  - In `RUN` with `dmem_wen=1`, `mem[idx] <= dmem_data` at the clock edge and `wr_count` increments.
  - `wr_count` saturates at all-ones.
  - In `CLEAR`, stores are dropped and not counted.
- Debug read:
  - `dbg_req_ready = (state==RUN)`.
  - On acceptance, the next cycle shows `dbg_rsp_valid=1` and `dbg_rsp_data = mem[dbg_addr]` as sampled at the accept edge.
  - Back-to-back requests give back-to-back responses.
- Same-cycle debug read and core store to the same index: the debug response returns the old (pre-store) value.
- No byte lanes, no misalignment handling; every access is a full word.

## Timing
- Reset values (asynchronous, `reset=0`):
  - state `CLEAR`, clear index 0.
  - `mem_ready=0`, `dbg_req_ready=0`, `dbg_rsp_valid=0`, `dbg_rsp_data=0`, `wr_count=0`.
- Array contents are not reset asynchronously; the `CLEAR` walk zeroes them.
- After reset deasserts, `CLEAR` lasts exactly DEPTH cycles. `mem_ready` and `dbg_req_ready` rise on the edge that writes index DEPTH-1 (cycle DEPTH after deassertion).
- The system holds the core in reset until `mem_ready=1`.
- Core load latency: 0 cycles (combinational).
- Store visibility:
  - Store data is visible to a core load in the following cycle.
  - A debug request accepted in the cycle after the store returns the new value.
- Debug latency: 1 cycle from accept to `dbg_rsp_valid`.
- Reset asserted mid-operation:
  - Immediate return to `CLEAR` and all outputs to their reset values.
  - A pending debug response is discarded.
  - The array is re-zeroed after deassertion.
- Index wrap: `dmem_addr` = 0x20 with DEPTH=32 addresses word 0.

## Structure
- Package `dmem_pkg`:
  - `typedef enum logic {CLEAR, RUN} dmem_state_t`.
  - Default `XLEN`, `DEPTH`, `CNT_W` constants.
- Single module. The array, FSM, debug register and counter are inline; no sub-module is warranted.
- Tristate drive: a continuous assign with `'z` when `dmem_wen=1`.

## Test plan
- Reset/init:
  - Stimulus: release `reset` after preloading garbage via a forced store.
  - Required: `mem_ready` rises 32 cycles later; debug reads of words 0, 17 and 31 return 0x00000000.
- Store/load:
  - Stimulus: store 0xDEADBEEF at `dmem_addr`=5 in `RUN`.
  - Required: next cycle with `dmem_wen=0`, `dmem_data`=0xDEADBEEF; `wr_count`=1.
- Store during `CLEAR`:
  - Stimulus: `dmem_wen=1`, data 0x12345678, address 3, at cycle 2 after reset release.
  - Required: word 3 reads 0 after init; `wr_count`=0.
- Debug collision:
  - Stimulus: word 7 holds 0x11; in one cycle, core stores 0x22 to address 7 and a debug request for 7 is accepted.
  - Required: response 0x11; the following debug read returns 0x22.
- Wrap and saturation:
  - Stimulus: store 0xA5 to `dmem_addr`=0x25.
  - Required: word 5 = 0xA5.
  - Stimulus: 65540 stores with `CNT_W`=16.
  - Required: `wr_count`=0xFFFF.
- Mid-operation reset:
  - Stimulus: assert `reset` in the same cycle a debug request is accepted.
  - Required: `dbg_rsp_valid` stays 0 and `mem_ready`=0 immediately; all words read 0 after the re-clear.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the data-memory responder.
//   dmem_state_t : CLEAR (post-reset zero-fill walk) / RUN (serving the core)
//   DMEM_*       : default word width, depth and store-counter width
package dmem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } dmem_state_t;

    localparam int DMEM_XLEN  = 32;
    localparam int DMEM_DEPTH = 32;
    localparam int DMEM_CNT_W = 16;

endpackage

// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle RV32I core.
// Holds a DEPTH-word register array, answers core loads combinationally,
// takes core stores on the rising edge, zero-fills itself after reset and
// offers a one-cycle-latency debug read port plus a saturating store count.
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   asynchronous active-low reset
//   dmem_addr     in   word index in [ADDR_BITS-1:0], upper bits ignored
//   dmem_wen      in   core store strobe
//   dmem_data     io   core drives on stores, this block drives on loads
//   mem_ready     out  zero-fill complete
//   dbg_req_valid in   debug read request
//   dbg_req_ready out  debug request can be accepted
//   dbg_addr      in   debug word index
//   dbg_rsp_valid out  one-cycle pulse carrying dbg_rsp_data
//   dbg_rsp_data  out  debug read data, held until the next response
//   wr_count      out  accepted core stores, saturating
//
// state | meaning
// ------+------------------------------------------------------------
// CLEAR | zero-fill walk, one word per cycle; loads read 0, stores dropped
// RUN   | normal service until the next reset
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int XLEN      = DMEM_XLEN,
    parameter int DEPTH     = DMEM_DEPTH,
    parameter int ADDR_BITS = $clog2(DEPTH),
    parameter int CNT_W     = DMEM_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [XLEN-1:0]      dmem_addr,
    input  logic                 dmem_wen,
    inout  wire  [XLEN-1:0]      dmem_data,
    output logic                 mem_ready,
    input  logic                 dbg_req_valid,
    output logic                 dbg_req_ready,
    input  logic [ADDR_BITS-1:0] dbg_addr,
    output logic                 dbg_rsp_valid,
    output logic [XLEN-1:0]      dbg_rsp_data,
    output logic [CNT_W-1:0]     wr_count
);

    localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(DEPTH - 1);

    dmem_state_t state;
    dmem_state_t state_next;

    logic [XLEN-1:0]      mem [DEPTH];
    logic [ADDR_BITS-1:0] clr_idx;
    logic [ADDR_BITS-1:0] idx;
    logic [XLEN-1:0]      rd_data;
    logic                 in_clear;
    logic                 store_ok;
    logic                 dbg_accept;
    logic                 unused_addr_bits;

    assign idx              = dmem_addr[ADDR_BITS-1:0];
    assign unused_addr_bits = ^dmem_addr[XLEN-1:ADDR_BITS];

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (clr_idx == LAST_IDX) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = CLEAR;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_clear      = 1'b1;
        mem_ready     = 1'b0;
        dbg_req_ready = 1'b0;
        if (state == RUN) begin
            in_clear      = 1'b0;
            mem_ready     = 1'b1;
            dbg_req_ready = 1'b1;
        end
    end

    assign store_ok   = !in_clear && dmem_wen;
    assign dbg_accept = dbg_req_valid && dbg_req_ready;

    // Array has no reset; the CLEAR walk is what zeroes it.
    always_ff @(posedge clk) begin
        if (in_clear) begin
            mem[clr_idx] <= '0;
        end else if (dmem_wen) begin
            mem[idx] <= dmem_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_idx       <= '0;
            dbg_rsp_valid <= 1'b0;
            dbg_rsp_data  <= '0;
            wr_count      <= '0;
        end else begin
            if (in_clear) begin
                clr_idx <= clr_idx + ADDR_BITS'(1);
            end
            dbg_rsp_valid <= dbg_accept;
            // Same-edge store to the same word lands after this read,
            // so the response carries the pre-store value.
            if (dbg_accept) begin
                dbg_rsp_data <= mem[dbg_addr];
            end
            if (store_ok && (wr_count != '1)) begin
                wr_count <= wr_count + CNT_W'(1);
            end
        end
    end

    // Unwritten words still hold garbage during the walk, so loads read 0.
    assign rd_data   = in_clear ? '0 : mem[idx];
    assign dmem_data = dmem_wen ? 'z : rd_data;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: init walk timing, loads/stores,
// CLEAR-time store drop, debug collision, wrap, saturation, mid-op reset.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dmem_addr;
    logic        dmem_wen;
    logic [31:0] core_data;
    wire  [31:0] dmem_data;
    logic        mem_ready;
    logic        dbg_req_valid;
    logic        dbg_req_ready;
    logic [4:0]  dbg_addr;
    logic        dbg_rsp_valid;
    logic [31:0] dbg_rsp_data;
    logic [15:0] wr_count;

    int vectors = 0;
    int miscompares = 0;
    int n;

    assign dmem_data = dmem_wen ? core_data : 'z;

    always #5 clk = ~clk;

    dmem_responder dut (
        .clk           (clk),
        .reset         (reset),
        .dmem_addr     (dmem_addr),
        .dmem_wen      (dmem_wen),
        .dmem_data     (dmem_data),
        .mem_ready     (mem_ready),
        .dbg_req_valid (dbg_req_valid),
        .dbg_req_ready (dbg_req_ready),
        .dbg_addr      (dbg_addr),
        .dbg_rsp_valid (dbg_rsp_valid),
        .dbg_rsp_data  (dbg_rsp_data),
        .wr_count      (wr_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        dmem_addr = addr;
        core_data = data;
        dmem_wen  = 1'b1;
        tick();
        dmem_wen  = 1'b0;
    endtask

    task automatic load_check(input string tag, input logic [31:0] addr, input logic [31:0] expected);
        dmem_wen  = 1'b0;
        dmem_addr = addr;
        #1;
        check(tag, dmem_data, expected);
    endtask

    task automatic dbg_check(input string tag, input logic [4:0] addr, input logic [31:0] expected);
        dbg_addr      = addr;
        dbg_req_valid = 1'b1;
        tick();
        dbg_req_valid = 1'b0;
        check({tag, "_valid"}, {31'd0, dbg_rsp_valid}, 32'd1);
        check(tag, dbg_rsp_data, expected);
    endtask

    task automatic wait_ready(input string tag, input int already, input int expected_cycles);
        n = 0;
        while (!mem_ready && n < 200) begin
            tick();
            n++;
        end
        check(tag, already + n, expected_cycles);
    endtask

    initial begin
        reset         = 1'b0;
        dmem_addr     = '0;
        dmem_wen      = 1'b0;
        core_data     = '0;
        dbg_req_valid = 1'b0;
        dbg_addr      = '0;
        tick();
        tick();

        check("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_dbg_ready", {31'd0, dbg_req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, dbg_rsp_valid}, 32'd0);
        check("rst_rsp_data", dbg_rsp_data, 32'd0);
        check("rst_wr_count", {16'd0, wr_count}, 32'd0);
        load_check("rst_load_zero", 32'd9, 32'd0);

        // First init: ready after exactly 32 edges
        reset = 1'b1;
        for (int i = 0; i < 31; i++) tick();
        check("init_not_ready_31", {31'd0, mem_ready}, 32'd0);
        tick();
        check("init_ready_32", {31'd0, mem_ready}, 32'd1);
        check("init_dbg_ready", {31'd0, dbg_req_ready}, 32'd1);

        // Garbage preload, then reset and re-clear
        store(32'd0,  32'hBAD0_0000);
        store(32'd17, 32'hBAD0_0017);
        store(32'd31, 32'hBAD0_0031);
        load_check("garbage_load17", 32'd17, 32'hBAD0_0017);
        check("garbage_wr_count", {16'd0, wr_count}, 32'd3);

        reset = 1'b0;
        #1;
        check("rst2_wr_count", {16'd0, wr_count}, 32'd0);
        check("rst2_mem_ready", {31'd0, mem_ready}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        tick();
        load_check("clear_load_zero", 32'd17, 32'd0);
        store(32'd3, 32'h1234_5678);
        check("clear_store_dropped_cnt", {16'd0, wr_count}, 32'd0);
        wait_ready("reinit_cycles", 3, 32);

        dbg_check("dbg_w0", 5'd0, 32'd0);
        dbg_check("dbg_w17", 5'd17, 32'd0);
        dbg_check("dbg_w31", 5'd31, 32'd0);
        dbg_check("dbg_w3", 5'd3, 32'd0);
        check("after_init_wr_count", {16'd0, wr_count}, 32'd0);
        tick();
        check("rsp_pulse_low", {31'd0, dbg_rsp_valid}, 32'd0);
        check("rsp_data_held", dbg_rsp_data, 32'd0);

        // Store / load
        store(32'd5, 32'hDEAD_BEEF);
        load_check("load_w5", 32'd5, 32'hDEAD_BEEF);
        check("wr_count_1", {16'd0, wr_count}, 32'd1);

        // Debug collision on word 7
        store(32'd7, 32'h0000_0011);
        dmem_addr     = 32'd7;
        core_data     = 32'h0000_0022;
        dmem_wen      = 1'b1;
        dbg_addr      = 5'd7;
        dbg_req_valid = 1'b1;
        tick();
        dmem_wen      = 1'b0;
        dbg_req_valid = 1'b0;
        check("collide_valid", {31'd0, dbg_rsp_valid}, 32'd1);
        check("collide_old", dbg_rsp_data, 32'h0000_0011);
        check("collide_wr_count", {16'd0, wr_count}, 32'd3);
        dbg_check("collide_new", 5'd7, 32'h0000_0022);

        // Back-to-back debug reads
        dbg_addr      = 5'd5;
        dbg_req_valid = 1'b1;
        tick();
        check("b2b_first", dbg_rsp_data, 32'hDEAD_BEEF);
        dbg_addr = 5'd7;
        tick();
        dbg_req_valid = 1'b0;
        check("b2b_second_valid", {31'd0, dbg_rsp_valid}, 32'd1);
        check("b2b_second", dbg_rsp_data, 32'h0000_0022);

        // Store then debug read next cycle
        store(32'd9, 32'h0000_0033);
        dbg_check("store_then_dbg", 5'd9, 32'h0000_0033);

        // Index wrap
        store(32'h25, 32'h0000_00A5);
        load_check("wrap_load_w5", 32'd5, 32'h0000_00A5);
        dbg_check("wrap_dbg_w5", 5'd5, 32'h0000_00A5);
        load_check("wrap_load_0x20", 32'h20, 32'd0);
        check("wrap_wr_count", {16'd0, wr_count}, 32'd5);

        // Mid-operation reset with a response in flight
        dbg_addr      = 5'd9;
        dbg_req_valid = 1'b1;
        tick();
        dbg_req_valid = 1'b0;
        check("midrst_accepted", {31'd0, dbg_rsp_valid}, 32'd1);
        reset = 1'b0;
        #1;
        check("midrst_rsp_valid", {31'd0, dbg_rsp_valid}, 32'd0);
        check("midrst_mem_ready", {31'd0, mem_ready}, 32'd0);
        check("midrst_rsp_data", dbg_rsp_data, 32'd0);
        check("midrst_wr_count", {16'd0, wr_count}, 32'd0);
        tick();
        check("midrst_hold_valid", {31'd0, dbg_rsp_valid}, 32'd0);
        reset = 1'b1;
        wait_ready("midrst_reinit", 0, 32);
        for (int i = 0; i < 32; i++) begin
            load_check($sformatf("reclear_w%0d", i), i, 32'd0);
        end
        dbg_check("reclear_dbg_w9", 5'd9, 32'd0);

        // Saturation: 65535 stores reach all-ones, 5 more stay there
        dmem_addr = 32'd12;
        core_data = 32'h0000_5A5A;
        dmem_wen  = 1'b1;
        for (int i = 0; i < 65534; i++) tick();
        check("sat_65534", {16'd0, wr_count}, 32'h0000_FFFE);
        tick();
        check("sat_65535", {16'd0, wr_count}, 32'h0000_FFFF);
        for (int i = 0; i < 5; i++) tick();
        dmem_wen = 1'b0;
        check("sat_65540", {16'd0, wr_count}, 32'h0000_FFFF);
        load_check("sat_last_data", 32'd12, 32'h0000_5A5A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
